// File: rtl/alu_addsub_seq.sv
// rtl/alu_addsub_seq.sv - chunk-serial adder/subtractor with ALU status flags
//
// Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, rippling the
// carry through a register, then presents the result with Sign/Zero/Parity/
// Overflow/carry-out flags behind a valid/ready handshake.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready high only in IDLE)
//   A, B, Cin, Sub      operands, carry/borrow-in, 0=add 1=subtract
//   out_valid/out_ready result handshake
//   S, Cout             result and carry-out (sub: 1 means no borrow)
//   Sign, Zero, Parity, Overflow  status flags of S
module alu_addsub_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Sign,
  output logic             Zero,
  output logic             Parity,
  output logic             Overflow
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NCH - 1);

  if ((WIDTH < 2) || (CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_param_err
    $error("alu_addsub_seq: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] bx_q, bx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             sign_q, sign_d;
  logic             zero_q, zero_d;
  logic             parity_q, parity_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] acc_shift;
  logic             a_msb;
  logic             bx_msb;

  always_comb begin
    // Operands are consumed LSB-first; the low chunk always holds the bits
    // for the current step, so on the last step it holds the operand MSBs.
    chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, bx_q[CHUNK-1:0]} + (CHUNK+1)'(carry_q);
    acc_shift = (acc_q >> CHUNK) | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
    a_msb     = a_q[CHUNK-1];
    bx_msb    = bx_q[CHUNK-1];

    state_d  = state_q;
    a_d      = a_q;
    bx_d     = bx_q;
    carry_d  = carry_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    s_d      = s_q;
    cout_d   = cout_q;
    sign_d   = sign_q;
    zero_d   = zero_q;
    parity_d = parity_q;
    ovf_d    = ovf_q;

    case (state_q)
      ST_IDLE: begin
        // in_ready_q gates acceptance so nothing is taken in the cycle
        // right after reset release.
        if (in_valid && in_ready_q) begin
          a_d     = A;
          bx_d    = Sub ? ~B : B;
          carry_d = Sub ? ~Cin : Cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> CHUNK;
        bx_d    = bx_q >> CHUNK;
        carry_d = chunk_sum[CHUNK];
        acc_d   = acc_shift;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          s_d      = acc_shift;
          cout_d   = chunk_sum[CHUNK];
          sign_d   = acc_shift[WIDTH-1];
          zero_d   = (acc_shift == '0);
          parity_d = ~^acc_shift;
          ovf_d    = (a_msb & bx_msb & ~acc_shift[WIDTH-1]) |
                     (~a_msb & ~bx_msb & acc_shift[WIDTH-1]);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      bx_q        <= '0;
      carry_q     <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      sign_q      <= 1'b0;
      zero_q      <= 1'b0;
      parity_q    <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      bx_q        <= bx_d;
      carry_q     <= carry_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      s_q         <= s_d;
      cout_q      <= cout_d;
      sign_q      <= sign_d;
      zero_q      <= zero_d;
      parity_q    <= parity_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign S         = s_q;
  assign Cout      = cout_q;
  assign Sign      = sign_q;
  assign Zero      = zero_q;
  assign Parity    = parity_q;
  assign Overflow  = ovf_q;

endmodule

// File: tb/tb_alu_addsub_seq.sv
// tb/tb_alu_addsub_seq.sv - directed and random checks of alu_addsub_seq
module tb_alu_addsub_seq;

  localparam int NOPS = 300;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_ready, Cin, Sub, out_valid, out_ready;
  logic [15:0] A, B, S;
  logic        Cout, Sign, Zero, Parity, Overflow;

  int n_cmp = 0;
  int n_bad = 0;
  int gen_done = 0;

  alu_addsub_seq #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .Sub(Sub), .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .Cout(Cout), .Sign(Sign), .Zero(Zero), .Parity(Parity), .Overflow(Overflow)
  );

  typedef struct {
    logic [15:0] a, b;
    logic        cin, sub;
    logic [15:0] s;
    logic        cout, sign, zero, par, ovf;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // {ovf, parity, zero, sign, cout, s}
  function automatic logic [20:0] model(input logic [15:0] a, b, input logic cin, sub);
    logic [15:0] bx;
    logic        c0;
    logic [16:0] r;
    logic        ovf;
    bx  = sub ? ~b : b;
    c0  = sub ? ~cin : cin;
    r   = {1'b0, a} + {1'b0, bx} + 17'(c0);
    ovf = (a[15] & bx[15] & ~r[15]) | (~a[15] & ~bx[15] & r[15]);
    return {ovf, ~^r[15:0], (r[15:0] == 16'h0), r[15], r[16], r[15:0]};
  endfunction

  task automatic accept_op(input logic [15:0] a, b, input logic cin, sub);
    int t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    chk("accept_ready", in_ready, 1);
    A = a; B = b; Cin = cin; Sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = 16'($urandom); B = 16'($urandom); Cin = ~cin; Sub = ~sub;
    chk("in_ready_run", in_ready, 0);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic check_out(input string tag, input logic [15:0] s,
                           input logic cout, sign, zero, par, ovf);
    chk({tag, ".S"}, S, s);
    chk({tag, ".Cout"}, Cout, cout);
    chk({tag, ".Sign"}, Sign, sign);
    chk({tag, ".Zero"}, Zero, zero);
    chk({tag, ".Parity"}, Parity, par);
    chk({tag, ".Overflow"}, Overflow, ovf);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_drop", out_valid, 0);
  endtask

  initial begin
    int lat;
    int t;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;

    vecs[0]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{16'h0005, 16'h0005, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{16'h00F0, 16'h0F00, 1'b0, 1'b0, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready", in_ready, 0);
    chk("rst.out_valid", out_valid, 0);
    check_out("rst", 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel.in_ready", in_ready, 1);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      accept_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      wait_result(lat);
      chk($sformatf("v%0d.latency", i), lat, 4);
      check_out($sformatf("v%0d", i), vecs[i].s, vecs[i].cout, vecs[i].sign,
                vecs[i].zero, vecs[i].par, vecs[i].ovf);
      consume();
    end

    // Backpressure: outputs frozen in DONE while inputs wiggle
    accept_op(16'h1234, 16'h1111, 1'b1, 1'b0);
    wait_result(lat);
    for (int i = 0; i < 3; i++) begin
      in_valid = ~in_valid;
      A = 16'($urandom); B = 16'($urandom);
      @(posedge clk); #1;
      chk("bp.out_valid", out_valid, 1);
      chk("bp.in_ready", in_ready, 0);
      check_out("bp", 16'h2346, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    in_valid = 1'b0;
    consume();
    check_out("bp_hold", 16'h2346, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("bp.in_ready_after", in_ready, 1);
    accept_op(16'h0005, 16'h0007, 1'b0, 1'b1);
    wait_result(lat);
    chk("bp_next.latency", lat, 4);
    check_out("bp_next", 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    consume();

    // Reset in the second RUN cycle
    accept_op(16'h1234, 16'h1111, 1'b1, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst.out_valid", out_valid, 0);
    chk("mid_rst.in_ready", in_ready, 0);
    check_out("mid_rst", 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst.in_ready_rel", in_ready, 1);
    chk("mid_rst.no_result", out_valid, 0);
    accept_op(16'h8000, 16'h0001, 1'b0, 1'b1);
    wait_result(lat);
    chk("post_rst.latency", lat, 4);
    check_out("post_rst", 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    consume();

    t = 0;
    while (gen_done < 3 && t < 30000) begin
      @(posedge clk); t++;
    end
    chk("random_done", gen_done, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Random traffic with random out_ready for CHUNK = 1, 4, 16
  for (genvar g = 0; g < 3; g++) begin : g_rnd
    localparam int CH = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
    localparam int NC = 16 / CH;

    logic        r_rst_n, r_in_valid, r_in_ready, r_cin, r_sub, r_out_valid, r_out_ready;
    logic [15:0] r_a, r_b, r_s;
    logic        r_cout, r_sign, r_zero, r_par, r_ovf;

    alu_addsub_seq #(.WIDTH(16), .CHUNK(CH)) u_rnd (
      .clk(clk), .rst_n(r_rst_n), .in_valid(r_in_valid), .in_ready(r_in_ready),
      .A(r_a), .B(r_b), .Cin(r_cin), .Sub(r_sub), .out_valid(r_out_valid),
      .out_ready(r_out_ready), .S(r_s), .Cout(r_cout), .Sign(r_sign), .Zero(r_zero),
      .Parity(r_par), .Overflow(r_ovf)
    );

    initial begin
      logic [15:0] a, b;
      logic        cin, sub, hs;
      logic [20:0] exp;
      int          lat, t;
      r_rst_n = 1'b0; r_in_valid = 1'b0; r_out_ready = 1'b0;
      r_a = '0; r_b = '0; r_cin = 1'b0; r_sub = 1'b0;
      repeat (2) @(posedge clk);
      #1 r_rst_n = 1'b1;
      @(posedge clk); #1;
      for (int n = 0; n < NOPS; n++) begin
        a   = 16'($urandom);
        b   = 16'($urandom);
        if (n % 4 == 0) b = ~a;
        if (n % 7 == 0) a = 16'h8000;
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
        t = 0;
        while (!r_in_ready && t < 50) begin
          @(posedge clk); #1; t++;
        end
        r_a = a; r_b = b; r_cin = cin; r_sub = sub; r_in_valid = 1'b1;
        @(posedge clk); #1;
        r_in_valid = 1'b0;
        r_a = 16'($urandom); r_b = 16'($urandom); r_cin = ~cin; r_sub = ~sub;
        exp = model(a, b, cin, sub);
        lat = 0;
        while (!r_out_valid && lat < 100) begin
          @(posedge clk); #1; lat++;
        end
        chk($sformatf("rnd_c%0d.latency", CH), lat, NC);
        chk($sformatf("rnd_c%0d.result", CH), {r_ovf, r_par, r_zero, r_sign, r_cout, r_s}, exp);
        hs = 1'b0;
        t  = 0;
        while (!hs) begin
          r_out_ready = (t == 15) ? 1'b1 : 1'($urandom_range(0, 1));
          hs = r_out_ready;
          @(posedge clk); #1;
          t++;
          if (!hs)
            chk($sformatf("rnd_c%0d.hold", CH),
                {r_out_valid, r_ovf, r_par, r_zero, r_sign, r_cout, r_s}, {1'b1, exp});
        end
        r_out_ready = 1'b0;
        chk($sformatf("rnd_c%0d.out_valid_drop", CH), r_out_valid, 0);
      end
      gen_done++;
    end
  end

endmodule
